// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Byte-lane enables for an access of the given size at a byte offset in the word.
  function automatic logic [3:0] lsu_byte_en(input lsu_size_e size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Single-outstanding request/acknowledge data-memory port.
interface lsu_ctrl_if #(
  parameter int unsigned AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store-data replication and load lane extract with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o
);

  logic [31:0] lane;

  // Replicate the LSB-aligned store data across every lane it could occupy.
  always_comb begin
    wdata_rep_o = wdata_i;
    case (size_i)
      SZ_B:    wdata_rep_o = {4{wdata_i[7:0]}};
      SZ_H:    wdata_rep_o = {2{wdata_i[15:0]}};
      default: wdata_rep_o = wdata_i;
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  always_comb begin
    lane        = rdata_i >> {offset_i, 3'b000};
    rdata_ext_o = lane;
    case (size_i)
      SZ_B:    rdata_ext_o = {{24{~unsigned_i & lane[7]}}, lane[7:0]};
      SZ_H:    rdata_ext_o = {{16{~unsigned_i & lane[15]}}, lane[15:0]};
      default: rdata_ext_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller with a single-outstanding memory port.
// Optional macro LSU_TIMEOUT_EN: abort a request not acknowledged within TIMEOUT_CYCLES.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_store,
  input  logic          lb,
  input  logic          lh,
  input  logic          lbu,
  input  logic          lhu,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  lsu_ctrl_if.master    mem,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [31:0]   rdata
);

  lsu_state_e    state_q;
  lsu_size_e     size_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          req_q;
  logic          busy_q;
  logic          done_q;
  logic          fault_q;
  logic [31:0]   rdata_q;

  lsu_size_e     size_d;
  logic          misalign_d;
  logic [31:0]   wdata_rep_d;
  logic [31:0]   rdata_ext_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] tmo_cnt_q;
`endif

  // Decode access size from the ALU flags; byte wins over halfword.
  always_comb begin
    size_d = SZ_W;
    if (lb) begin
      size_d = SZ_B;
    end else if (lh) begin
      size_d = SZ_H;
    end
  end

  assign misalign_d = lsu_misaligned(size_d, addr[1:0]);

  lsu_lane_align u_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .offset_i    (off_q),
    .wdata_i     (wdata_q),
    .rdata_i     (mem.mem_rdata),
    .wdata_rep_o (wdata_rep_d),
    .rdata_ext_o (rdata_ext_d)
  );

  // Access sequencer: command capture, request hold, completion/fault pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            size_q  <= size_d;
            uns_q   <= lbu | lhu;
            off_q   <= addr[1:0];
            wdata_q <= wdata;
            if (misaligned_guard(misalign_d)) begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              we_q    <= is_store;
              be_q    <= lsu_byte_en(size_d, addr[1:0]);
              addr_q  <= {addr[AW-1:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state_q <= RESP;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            if (!we_q) begin
              rdata_q <= rdata_ext_d;
            end
          end
`ifdef LSU_TIMEOUT_EN
          // Last waiting cycle: the count lands on TIMEOUT_CYCLES as the request drops.
          else if (tmo_cnt_q == TO_LAST) begin
            state_q   <= FAULT;
            req_q     <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= 1'b1;
            tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
          end
`endif
        end
        RESP, FAULT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic misaligned_guard(input logic mis);
    return mis;
  endfunction

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_rep_d;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_store, lb, lh, lbu, lhu;
  logic [31:0] addr, wdata;
  logic        busy, done, fault;
  logic [31:0] rdata;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_ctrl_if #(.AW(32)) mem_bus ();

  lsu_ctrl #(.AW(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_store (is_store),
    .lb       (lb),
    .lh       (lh),
    .lbu      (lbu),
    .lhu      (lhu),
    .addr     (addr),
    .wdata    (wdata),
    .mem      (mem_bus),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one command for a single cycle; returns just after the sampling edge.
  task automatic issue(input logic st, input logic b, input logic h, input logic bu,
                       input logic hu, input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; is_store = st; lb = b; lh = h; lbu = bu; lhu = hu;
    addr = a; wdata = wd;
    step();
    start = 1'b0;
  endtask

  // Acknowledge the pending request in the current cycle.
  task automatic ack_now(input logic [31:0] rd);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = rd;
    step();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0;
    lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0;
    addr = '0; wdata = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    step(); step();

    chk("rst_req",   32'(mem_bus.mem_req), 32'd0);
    chk("rst_we",    32'(mem_bus.mem_we), 32'd0);
    chk("rst_be",    32'(mem_bus.mem_be), 32'd0);
    chk("rst_addr",  mem_bus.mem_addr, 32'd0);
    chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    step();

    // Signed byte load, ack in the first request cycle.
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1003, 32'h0);
    chk("lb_req",  32'(mem_bus.mem_req), 32'd1);
    chk("lb_we",   32'(mem_bus.mem_we), 32'd0);
    chk("lb_be",   32'(mem_bus.mem_be), 32'h8);
    chk("lb_addr", mem_bus.mem_addr, 32'h1000);
    chk("lb_busy", 32'(busy), 32'd1);
    chk("lb_done0", 32'(done), 32'd0);
    ack_now(32'h8011_2233);
    chk("lb_done",  32'(done), 32'd1);
    chk("lb_fault", 32'(fault), 32'd0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_req_off", 32'(mem_bus.mem_req), 32'd0);
    chk("lb_busy_resp", 32'(busy), 32'd1);
    step();
    chk("lb_done_clr", 32'(done), 32'd0);
    chk("lb_idle", 32'(busy), 32'd0);
    chk("lb_hold", rdata, 32'hFFFF_FF80);

    // Unsigned halfword load with three wait cycles.
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2002, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lhu_req",  32'(mem_bus.mem_req), 32'd1);
      chk("lhu_be",   32'(mem_bus.mem_be), 32'hC);
      chk("lhu_addr", mem_bus.mem_addr, 32'h2000);
      chk("lhu_nodone", 32'(done), 32'd0);
      step();
    end
    chk("lhu_req4", 32'(mem_bus.mem_req), 32'd1);
    ack_now(32'hBEEF_1234);
    chk("lhu_done",  32'(done), 32'd1);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    step();

    // Byte store: replicated data, rdata untouched.
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0000_00A5);
    chk("sb_we",    32'(mem_bus.mem_we), 32'd1);
    chk("sb_be",    32'(mem_bus.mem_be), 32'h1);
    chk("sb_wdata", mem_bus.mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr",  mem_bus.mem_addr, 32'h10);
    ack_now(32'h1111_1111);
    chk("sb_done",  32'(done), 32'd1);
    chk("sb_rdata", rdata, 32'h0000_BEEF);
    step();

    // Misaligned word load; a start during the fault cycle is ignored.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h06, 32'h0);
    start = 1'b1; addr = 32'h40;
    chk("mis_req",   32'(mem_bus.mem_req), 32'd0);
    chk("mis_done",  32'(done), 32'd1);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_busy",  32'(busy), 32'd1);
    chk("mis_rdata", rdata, 32'h0000_BEEF);
    step();
    start = 1'b0;
    chk("mis_req2",  32'(mem_bus.mem_req), 32'd0);
    chk("mis_done2", 32'(done), 32'd0);
    chk("mis_idle",  32'(busy), 32'd0);
    step();
    chk("mis_ign", 32'(mem_bus.mem_req), 32'd0);

    // Misaligned halfword store.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h1234);
    chk("mish_req",   32'(mem_bus.mem_req), 32'd0);
    chk("mish_fault", 32'(fault), 32'd1);
    step();

    // Ack while idle has no effect.
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    step(); step();
    mem_bus.mem_ack = 1'b0;
    chk("idle_ack_done",  32'(done), 32'd0);
    chk("idle_ack_rdata", rdata, 32'h0000_BEEF);

    // Word load.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    chk("lw_be", 32'(mem_bus.mem_be), 32'hF);
    ack_now(32'h1234_5678);
    chk("lw_rdata", rdata, 32'h1234_5678);
    step();

    // Signed halfword load, upper lane.
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h42, 32'h0);
    chk("lh_be", 32'(mem_bus.mem_be), 32'hC);
    ack_now(32'h8001_7FFF);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    step();

    // Unsigned byte load, lane 1.
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01, 32'h0);
    chk("lbu_be", 32'(mem_bus.mem_be), 32'h2);
    ack_now(32'h0000_FF00);
    chk("lbu_rdata", rdata, 32'h0000_00FF);
    step();

    // lb and lh both set: byte wins, so offset 3 is legal.
    issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h03, 32'h0);
    chk("prio_req", 32'(mem_bus.mem_req), 32'd1);
    chk("prio_be",  32'(mem_bus.mem_be), 32'h8);
    ack_now(32'h7F00_0000);
    chk("prio_rdata", rdata, 32'h0000_007F);
    step();

    // Halfword and word stores.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h02, 32'h1234_ABCD);
    chk("sh_be",    32'(mem_bus.mem_be), 32'hC);
    chk("sh_wdata", mem_bus.mem_wdata, 32'hABCD_ABCD);
    ack_now(32'h0);
    step();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0102_0304);
    chk("sw_be",    32'(mem_bus.mem_be), 32'hF);
    chk("sw_wdata", mem_bus.mem_wdata, 32'h0102_0304);
    ack_now(32'h0);
    chk("sw_rdata", rdata, 32'h0000_007F);
    step();

    // Reset in the middle of a request.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0);
    chk("rr_req", 32'(mem_bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rr_req_drop", 32'(mem_bus.mem_req), 32'd0);
    chk("rr_busy",     32'(busy), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_nodone", 32'(done), 32'd0);
    end
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h84, 32'h0);
    chk("rr_next_req", 32'(mem_bus.mem_req), 32'd1);
    ack_now(32'hA5A5_5A5A);
    chk("rr_next_done",  32'(done), 32'd1);
    chk("rr_next_rdata", rdata, 32'hA5A5_5A5A);
    step();

`ifdef LSU_TIMEOUT_EN
    // No ack: request held TO cycles, then a fault completion.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h90, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(mem_bus.mem_req), 32'd1);
      step();
    end
    chk("to_req_drop", 32'(mem_bus.mem_req), 32'd0);
    chk("to_done",     32'(done), 32'd1);
    chk("to_fault",    32'(fault), 32'd1);
    chk("to_rdata",    rdata, 32'hA5A5_5A5A);
    step();
    chk("to_idle", 32'(busy), 32'd0);

    // Ack on the last allowed cycle wins.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h94, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("to2_req", 32'(mem_bus.mem_req), 32'd1);
      step();
    end
    ack_now(32'h0BAD_F00D);
    chk("to2_done",  32'(done), 32'd1);
    chk("to2_fault", 32'(fault), 32'd0);
    chk("to2_rdata", rdata, 32'h0BAD_F00D);
    step();
`else
    // Without the timeout the request waits indefinitely.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h90, 32'h0);
    repeat (20) step();
    chk("wait_req",  32'(mem_bus.mem_req), 32'd1);
    chk("wait_done", 32'(done), 32'd0);
    ack_now(32'h0BAD_F00D);
    chk("wait_done2", 32'(done), 32'd1);
    chk("wait_fault", 32'(fault), 32'd0);
    chk("wait_rdata", rdata, 32'h0BAD_F00D);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Multi-cycle load/store controller for the riscv32i core. It consumes the size/sign flags from the ALU decoder (lb, lh, lbu, lhu), the computed address and the store data, and drives a single-outstanding request/acknowledge data-memory port. It returns sign- or zero-extended load data to writeback with a one-cycle done pulse. The datapath holds the issuing stage while busy is high.

Parameters:
AW, 32, address width in bits.
TIMEOUT_CYCLES, 16, cycles mem_req may wait for mem_ack before abort. Used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  issue one access; sampled only in IDLE
is_store  in  1  1=store, 0=load
lb  in  1  byte access (also asserted with lbu)
lh  in  1  halfword access (also asserted with lhu)
lbu  in  1  unsigned byte load
lhu  in  1  unsigned halfword load
addr  in  AW  byte address
wdata  in  32  store data, LSB-aligned
mem_req  out  1  request valid
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_addr  out  AW  word address, addr with bits [1:0] forced to 0
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  request accepted/completed this cycle
mem_rdata  in  32  read word, valid when mem_ack is high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
fault  out  1  qualifies done: access aborted
rdata  out  32  extended load data, held until next done

Behaviour:
- Reset values: all outputs 0. State is IDLE.
- Size: lb=1 selects byte, which takes priority if lb and lh are both set. Otherwise lh=1 selects halfword. Otherwise the access is a word. Unsigned = lbu|lhu.
- The IDLE state registers the command on start. start asserted in any state other than IDLE is ignored.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Go to FAULT. No memory request is issued.
  - Next cycle: done=1, fault=1, rdata unchanged. Then return to IDLE.
- Aligned access: go to REQ.
  - mem_req rises in the cycle after start.
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata stay stable until the cycle in which mem_ack=1.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte replicated 4x; half replicated 2x; word unchanged. mem_be is ignored on loads, but is driven identically.
- REQ with mem_ack=1:
  - Capture the load lane: mem_rdata>>(8*addr[1:0]).
  - Extend to 32 bits: bit 7 (byte) or bit 15 (half) when signed, zero when unsigned.
  - Go to RESP.
- RESP: done=1, fault=0, rdata valid (rdata not updated for stores). Return to IDLE.
- Latency: start in cycle 0 and mem_ack in cycle k (k≥1) give done in cycle k+1. The minimum is 2 cycles. A new start is accepted in the cycle after done.
- mem_ack while not in REQ is ignored.
- Reset asserted mid-access: mem_req drops immediately (asynchronous). Any in-flight access is abandoned and done is not issued.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments each REQ cycle without mem_ack.
  - At a count of TIMEOUT_CYCLES, mem_req drops and the FSM goes to FAULT, giving done=1, fault=1 one cycle later.
  - mem_ack in the same cycle the limit is reached wins: the access completes normally.
- Undefined: REQ waits indefinitely; fault arises only from misalignment.

Decomposition:
- Package lsu_pkg:
  - state enum IDLE/REQ/RESP/FAULT;
  - size encoding SZ_B/SZ_H/SZ_W (2 bits);
  - function computing byte enables from size and offset.
- Sub-module lsu_lane_align (combinational):
  - store-data replication;
  - load lane extract plus sign/zero extend.
- lsu_ctrl holds the FSM, the command registers and the optional timeout counter.

Test Plan:
- Load byte signed: lb=1, addr=0x1003, mem_rdata=0x80112233, ack 1 cycle later -> mem_be=4'b1000, mem_addr=0x1000, rdata=0xFFFFFF80, done 2 cycles after start.
- Load half unsigned: lh=lhu=1, addr=0x2002, mem_rdata=0xBEEF1234, ack after 3 wait cycles -> rdata=0x0000BEEF; mem_req stable throughout; done 1 cycle after ack.
- Store byte: is_store=1, lb=1, addr=0x10, wdata=0x000000A5 -> mem_we=1, mem_be=4'b0001, mem_wdata=0xA5A5A5A5; rdata unchanged.
- Misaligned word: addr=0x06, load -> mem_req never asserted; done=fault=1 in cycle after start; start during that window ignored.
- Reset during REQ: assert reset with mem_req=1 -> mem_req=0, busy=0 immediately; no done pulse; next start proceeds normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then low; done=fault=1 next cycle. A repeat run with ack on the 4th cycle completes normally with fault=0.
